// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. After reset it clears the whole memory with a write sweep. It
// then grants one requester per cycle, rotating priority when both requesters are active.
module mem_arbiter #(
    parameter int unsigned C_ADDRSIZE = 10,
    parameter int unsigned C_WORDSIZE = 8
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_req0,
    input  logic                  I_req1,
    input  logic                  I_wen0,
    input  logic                  I_wen1,
    input  logic [C_ADDRSIZE-1:0] I_addr0,
    input  logic [C_ADDRSIZE-1:0] I_addr1,
    input  logic [C_WORDSIZE-1:0] I_wdata0,
    input  logic [C_WORDSIZE-1:0] I_wdata1,
    output logic                  O_gnt0,
    output logic                  O_gnt1,
    output logic                  O_rvalid0,
    output logic                  O_rvalid1,
    output logic [C_WORDSIZE-1:0] O_rdata0,
    output logic [C_WORDSIZE-1:0] O_rdata1,
    output logic                  O_mem_wen,
    output logic [C_ADDRSIZE-1:0] O_mem_addr,
    output logic [C_WORDSIZE-1:0] O_mem_wdata,
    input  logic [C_WORDSIZE-1:0] I_mem_rdata,
    output logic                  O_busy
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [C_ADDRSIZE-1:0] CntLast = '1;

    state_e                  state_q, state_d;
    logic [C_ADDRSIZE-1:0]   cnt_q, cnt_d;
    logic                    prio_q, prio_d;      // requester that wins a tie
    logic                    rvalid0_q, rvalid0_d;
    logic                    rvalid1_q, rvalid1_d;
    logic [C_WORDSIZE-1:0]   rdata0_q, rdata0_d;
    logic [C_WORDSIZE-1:0]   rdata1_q, rdata1_d;
    logic                    run;
    logic                    gnt0, gnt1;

    // Grant decode: blocked during the clear sweep and in any cycle that has reset asserted.
    always_comb begin
        run  = (state_q == StRun) && !I_rst;
        gnt0 = run && I_req0 && (!I_req1 || !prio_q);
        gnt1 = run && I_req1 && (!I_req0 || prio_q);
    end

    // Memory port mux: sweep writes zeros in INIT; in RUN it follows the granted requester.
    always_comb begin
        O_mem_wen   = 1'b0;
        O_mem_addr  = '0;
        O_mem_wdata = '0;
        if (state_q == StInit) begin
            O_mem_wen  = 1'b1;
            O_mem_addr = cnt_q;
        end else if (gnt0) begin
            O_mem_wen   = I_wen0;
            O_mem_addr  = I_addr0;
            O_mem_wdata = I_wdata0;
        end else if (gnt1) begin
            O_mem_wen   = I_wen1;
            O_mem_addr  = I_addr1;
            O_mem_wdata = I_wdata1;
        end
    end

    // Next-state: sweep counter, priority rotation and read-return capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        if (state_q == StInit) begin
            cnt_d = cnt_q + 1'b1;  // wraps to zero after the last address
            if (cnt_q == CntLast) begin
                state_d = StRun;
            end
        end
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
        rvalid0_d = gnt0 && !I_wen0;
        rvalid1_d = gnt1 && !I_wen1;
        rdata0_d  = rvalid0_d ? I_mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? I_mem_rdata : rdata1_q;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            prio_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign O_gnt0    = gnt0;
    assign O_gnt1    = gnt1;
    assign O_rvalid0 = rvalid0_q;
    assign O_rvalid1 = rvalid1_q;
    assign O_rdata0  = rdata0_q;
    assign O_rdata1  = rdata1_q;
    assign O_busy    = (state_q == StInit) || I_rst;

endmodule
